// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants
// for the PS/2 keyboard receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ps2_key_t;

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchroniser plus
// glitch filter for one PS/2 line.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_raw,
  output logic line_filt
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          filt_q;

  // synchronise the raw pin into clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], line_raw};
    end
  end

  // flip level after FILTER_LEN equal samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else if (sync_q[1] == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q  <= '0;
      filt_q <= sync_q[1];
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign line_filt = filt_q;

endmodule

// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 frame receiver with
// E0/F0 prefix folding into key events.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_break,
  output logic       key_ext,
  output logic       err_parity,
  output logic       err_frame
);

  localparam logic [16:0] TMO_LAST =
    17'(TIMEOUT_CYCLES - 1);

  ps2_state_t  state_q, state_d;
  logic        clk_f, data_f, clk_prev;
  logic        fall, tmo_hit;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        par_bit;
  logic [16:0] tmo_cnt;
  logic        frame_err_d, par_err_d, byte_ok_d;
  logic        ext_pend, brk_pend;
  logic        kv_q, ep_q, ef_q;
  ps2_key_t    key_q;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filt (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_raw (ps2_clk),
    .line_filt(clk_f)
  );

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_data_filt (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_raw (ps2_data),
    .line_filt(data_f)
  );

  assign fall    = clk_prev & ~clk_f;
  assign tmo_hit = (state_q != IDLE) && !fall
                && (tmo_cnt == TMO_LAST);

  // previous filtered clock for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clk_prev <= 1'b1;
    else        clk_prev <= clk_f;
  end

  // frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state and per-frame verdicts
  always_comb begin
    state_d     = state_q;
    frame_err_d = 1'b0;
    par_err_d   = 1'b0;
    byte_ok_d   = 1'b0;
    if (tmo_hit) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (data_f) frame_err_d = 1'b1;
          else        state_d     = DATA;
        end
        DATA: begin
          if (bit_cnt == 3'd7) state_d = PARITY;
        end
        PARITY: state_d = STOP;
        STOP: begin
          state_d = IDLE;
          if (!data_f)
            frame_err_d = 1'b1;
          else if (!(^{shreg, par_bit}))
            par_err_d = 1'b1;
          else
            byte_ok_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // shift register, bit count, parity capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else if (fall) begin
      if (state_q == IDLE) bit_cnt <= '0;
      if (state_q == DATA) begin
        shreg   <= {data_f, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state_q == PARITY) par_bit <= data_f;
    end
  end

  // saturating inter-edge timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (fall) begin
      tmo_cnt <= '0;
    end else if (state_q != IDLE && tmo_cnt != '1) begin
      tmo_cnt <= tmo_cnt + 17'd1;
    end
  end

  // prefix folding and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kv_q     <= 1'b0;
      ep_q     <= 1'b0;
      ef_q     <= 1'b0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      key_q    <= '0;
    end else begin
      kv_q <= 1'b0;
      ep_q <= par_err_d;
      ef_q <= frame_err_d;
      if (frame_err_d || par_err_d) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_ok_d) begin
        unique case (1'b1)
          (shreg == PS2_PREFIX_EXT): ext_pend <= 1'b1;
          (shreg == PS2_PREFIX_BRK): brk_pend <= 1'b1;
          default: begin
            kv_q       <= 1'b1;
            key_q.code <= shreg;
            key_q.brk  <= brk_pend;
            key_q.ext  <= ext_pend;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign key_valid  = kv_q;
  assign key_code   = key_q.code;
  assign key_break  = key_q.brk;
  assign key_ext    = key_q.ext;
  assign err_parity = ep_q;
  assign err_frame  = ef_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb_ps2_key_rx: scoreboard bench with a
// frame-level reference model.
module tb_ps2_key_rx;

  localparam int HALF = 16;
  localparam int GAP  = 60;
  localparam int TMO  = 65000;
  localparam int LAT  = 7;

  typedef struct {
    int         kind;
    logic [7:0] code;
    logic       brk;
    logic       ext;
    longint     due;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_ext;
  logic       err_parity;
  logic       err_frame;

  longint cyc = 0;
  int     n_cmp = 0;
  int     n_err = 0;
  ev_t    q[$];

  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  logic [7:0] m_code = 8'h00;
  logic       m_kbrk = 1'b0;
  logic       m_kext = 1'b0;

  ps2_key_rx #(
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_break (key_break),
    .key_ext   (key_ext),
    .err_parity(err_parity),
    .err_frame (err_frame)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm,
                              longint act,
                              longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h",
               nm, act, exp);
    end
  endfunction

  function automatic void push(int k,
                               logic [7:0] c,
                               logic b, logic e,
                               longint due);
    ev_t ev;
    ev.kind = k;
    ev.code = c;
    ev.brk  = b;
    ev.ext  = e;
    ev.due  = due;
    q.push_back(ev);
  endfunction

  // Reference: one complete frame's effect.
  function automatic void model_frame(
    logic [7:0] b, bit bad_par, bit bad_stop,
    longint due);
    if (bad_stop) begin
      push(2, 8'h00, 1'b0, 1'b0, due);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (bad_par) begin
      push(1, 8'h00, 1'b0, 1'b0, due);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      push(0, b, m_brk, m_ext, due);
      m_code = b;
      m_kbrk = m_brk;
      m_kext = m_ext;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
    end
  endfunction

  // Monitor: pop and compare on every pulse.
  always @(negedge clk) begin
    int   k;
    ev_t  e;
    if (rst_n && (key_valid | err_parity | err_frame)) begin
      chk("one_pulse",
          int'(key_valid) + int'(err_parity)
          + int'(err_frame), 1);
      k = key_valid ? 0 : (err_parity ? 1 : 2);
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got kind %0d at %0d required none",
                 k, cyc);
      end else begin
        e = q.pop_front();
        chk("kind", k, e.kind);
        chk("latency_cyc", cyc, e.due);
        if (e.kind == 0) begin
          chk("key_code", key_code, e.code);
          chk("key_break", key_break, e.brk);
          chk("key_ext", key_ext, e.ext);
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_hold();
    chk("hold_code", key_code, m_code);
    chk("hold_break", key_break, m_kbrk);
    chk("hold_ext", key_ext, m_kext);
  endtask

  task automatic check_zero();
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_break", key_break, 0);
    chk("rst_ext", key_ext, 0);
    chk("rst_perr", err_parity, 0);
    chk("rst_ferr", err_frame, 0);
  endtask

  task automatic send_frame(logic [7:0] b,
                            bit bad_par,
                            bit bad_stop,
                            int nfall,
                            bit glitch,
                            bit exp_tmo);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nfall; i++) begin
      ps2_data = bits[i];
      tick(HALF);
      ps2_clk = 1'b0;
      if (i == 10)
        model_frame(b, bad_par, bad_stop, cyc + LAT);
      if (exp_tmo && i == nfall - 1) begin
        push(2, 8'h00, 1'b0, 1'b0, cyc + LAT + TMO);
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
      tick(HALF);
      ps2_clk = 1'b1;
      if (glitch && i < 10) begin
        tick(4);
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
      end
    end
    ps2_data = 1'b1;
    ps2_clk  = 1'b1;
    tick(GAP);
    if (nfall == 11) check_hold();
  endtask

  task automatic lone_edge();
    ps2_data = 1'b1;
    tick(HALF);
    ps2_clk = 1'b0;
    push(2, 8'h00, 1'b0, 1'b0, cyc + LAT);
    m_ext = 1'b0;
    m_brk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
    tick(GAP);
  endtask

  initial begin
    logic [7:0] b;
    int         r;
    tick(5);
    check_zero();
    rst_n = 1'b1;
    tick(10);

    send_frame(8'h1C, 0, 0, 11, 0, 0);

    send_frame(8'hF0, 0, 0, 11, 0, 0);
    send_frame(8'hE0, 0, 0, 11, 0, 0);
    send_frame(8'h74, 0, 0, 11, 0, 0);
    send_frame(8'h1C, 0, 0, 11, 0, 0);

    send_frame(8'hF0, 0, 0, 11, 0, 0);
    send_frame(8'h1C, 1, 0, 11, 0, 0);
    send_frame(8'h1C, 0, 0, 11, 0, 0);

    send_frame(8'hE0, 0, 0, 11, 0, 0);
    send_frame(8'h12, 0, 0, 5, 0, 1);
    tick(TMO + 40);
    send_frame(8'h29, 0, 0, 11, 0, 0);

    send_frame(8'h3A, 0, 0, 11, 1, 0);

    send_frame(8'hF0, 0, 0, 11, 0, 0);
    lone_edge();
    send_frame(8'h33, 0, 0, 11, 0, 0);

    send_frame(8'hE0, 0, 0, 11, 0, 0);
    send_frame(8'h6B, 0, 1, 11, 0, 0);
    send_frame(8'h6B, 0, 0, 11, 0, 0);

    send_frame(8'h4D, 0, 0, 4, 0, 0);
    rst_n = 1'b0;
    tick(3);
    check_zero();
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_code = 8'h00;
    m_kbrk = 1'b0;
    m_kext = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    send_frame(8'h5A, 0, 0, 11, 0, 0);

    for (int n = 0; n < 20; n++) begin
      r = $urandom_range(0, 7);
      if (r < 2)       b = 8'hE0;
      else if (r < 4)  b = 8'hF0;
      else             b = 8'($urandom_range(0, 255));
      send_frame(b,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0,
                 11, $urandom_range(0, 3) == 0, 0);
    end

    tick(200);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
